// File: rtl/dcache_lsu.sv
// rtl/dcache_lsu.sv - load/store unit sequencing byte/half/word accesses onto a word-wide dcache
//
// Purpose: accepts one pipeline memory request at a time, reads/writes the
// data cache over a registered word-address port, performs big-endian lane
// extraction for loads (sign/zero extension) and read-merge-write for
// sub-word stores, and returns a one-cycle completion pulse.
//
// Optional feature: define LSU_UNALIGNED_EXC_EN to trap misaligned LW/SW and
// LH/LHU/SH (completes in one cycle with resp_err=1, no dcache access).
// Without it the low address bits below the access size are ignored.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/op/addr/wdata request from the pipeline (taken only when idle)
//   busy                    high whenever the unit is not idle
//   resp_valid/rdata/err    completion pulse, load data, misalignment flag
//   dc_wen/addr/wdata       registered dcache write enable, word address, data
//   dc_rdata                dcache read word, valid the cycle after dc_addr

module dcache_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dc_wen,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    input  logic [31:0] dc_rdata
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;     // address byte offset, selects the lane
    logic [15:0] wd_q, wd_d;     // only the low halfword is needed for SB/SH
    logic        dc_wen_q, dc_wen_d;
    logic [31:0] dc_addr_q, dc_addr_d;
    logic [31:0] dc_wdata_q, dc_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

`ifdef LSU_UNALIGNED_EXC_EN
    always_comb begin
        misal = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misal = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misal = req_addr[0];
            default:              misal = 1'b0;
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = 8'h00;
        case (lo_q)
            2'd0:    byte_sel = dc_rdata[31:24];
            2'd1:    byte_sel = dc_rdata[23:16];
            2'd2:    byte_sel = dc_rdata[15:8];
            default: byte_sel = dc_rdata[7:0];
        endcase
        half_sel = lo_q[1] ? dc_rdata[15:0] : dc_rdata[31:16];
    end

    always_comb begin
        load_val = dc_rdata;
        case (op_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            default: load_val = dc_rdata;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word just read.
    always_comb begin
        merged = dc_rdata;
        if (op_q == OP_SB) begin
            case (lo_q)
                2'd0:    merged[31:24] = wd_q[7:0];
                2'd1:    merged[23:16] = wd_q[7:0];
                2'd2:    merged[15:8]  = wd_q[7:0];
                default: merged[7:0]   = wd_q[7:0];
            endcase
        end else if (lo_q[1]) begin
            merged[15:0] = wd_q;
        end else begin
            merged[31:16] = wd_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lo_d       = lo_q;
        wd_d       = wd_q;
        dc_wen_d   = 1'b0;
        dc_addr_d  = dc_addr_q;
        dc_wdata_d = dc_wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    lo_d    = req_addr[1:0];
                    wd_d    = req_wdata[15:0];
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (misal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dc_addr_d = {2'b00, req_addr[31:2]};
                        if (req_op == OP_SW) begin
                            // Full word store needs no read, write right away.
                            dc_wen_d   = 1'b1;
                            dc_wdata_d = req_wdata;
                            state_d    = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (op_q[2:1] == 2'b11) begin
                    dc_wdata_d = merged;
                    dc_wen_d   = 1'b1;
                    state_d    = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WR: state_d = S_DONE;
            S_DONE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            lo_q       <= 2'b00;
            wd_q       <= 16'h0000;
            dc_wen_q   <= 1'b0;
            dc_addr_q  <= 32'h0;
            dc_wdata_q <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            wd_q       <= wd_d;
            dc_wen_q   <= dc_wen_d;
            dc_addr_q  <= dc_addr_d;
            dc_wdata_q <= dc_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dc_wen     = dc_wen_q;
    assign dc_addr    = dc_addr_q;
    assign dc_wdata   = dc_wdata_q;

endmodule

// File: tb/tb_dcache_lsu.sv
// tb/tb_dcache_lsu.sv - self-checking bench for dcache_lsu

module tb_dcache_lsu;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dc_wen;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [31:0] dc_rdata;

    always #5 clk = ~clk;

    dcache_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dc_wen     (dc_wen),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_rdata   (dc_rdata)
    );

    // Dcache model: one-cycle read latency, write on dc_wen, plus a bench preload port.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;
    int          wr_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] wr_addr_last = 32'h0;

    always @(posedge clk) begin
        dc_rdata <= mem[dc_addr[5:0]];
        if (pre_en) mem[pre_idx] <= pre_val;
        if (dc_wen) begin
            mem[dc_addr[5:0]] <= dc_wdata;
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= dc_addr;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wrs;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wrs;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        int   cnt;
        int   w0;
        v = vecs[i];
        preload(v.addr[7:2], v.init);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, v.exp_wrs});
        @(negedge clk);
        // Scramble the request inputs once accepted; they must not matter any more.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        cnt = 1;
        chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
        if (v.op == OP_SW && !v.exp_err) begin
            chk($sformatf("v%0d sw dc_wen", i), 32'(dc_wen), 32'd1);
            chk($sformatf("v%0d sw dc_addr", i), dc_addr, {2'b00, v.addr[31:2]});
            chk($sformatf("v%0d sw dc_wdata", i), dc_wdata, v.wdata);
        end
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        e = sb_q.pop_front();
        if (!resp_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL v%0d timeout: no resp_valid within %0d cycles", i, cnt);
        end else begin
            chk($sformatf("v%0d latency", i), 32'(cnt), 32'(e.lat));
            chk($sformatf("v%0d rdata", i), resp_rdata, e.rdata);
            chk($sformatf("v%0d err", i), 32'(resp_err), 32'(e.err));
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse", i), 32'({resp_valid, busy}), 32'd0);
        chk($sformatf("v%0d writes", i), 32'(wr_cnt - w0), 32'(e.wrs));
        chk($sformatf("v%0d mem", i), mem[v.addr[7:2]], v.exp_mem);
        if (e.wrs > 0) chk($sformatf("v%0d wr_addr", i), wr_addr_last, {2'b00, v.addr[31:2]});
    endtask

    initial begin
        int w0;
        int r0;
        logic rv_seen;
        logic wen_seen;

        vecs[0]  = '{OP_SW,  32'h10, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 2, 1, 32'hDEADBEEF};
        vecs[1]  = '{OP_LB,  32'h13, 32'h0,        32'h123456F0, 32'hFFFFFFF0, 1'b0, 3, 0, 32'h123456F0};
        vecs[2]  = '{OP_LBU, 32'h13, 32'h0,        32'h123456F0, 32'h000000F0, 1'b0, 3, 0, 32'h123456F0};
        vecs[3]  = '{OP_LH,  32'h10, 32'h0,        32'h123456F0, 32'h00001234, 1'b0, 3, 0, 32'h123456F0};
        vecs[4]  = '{OP_LHU, 32'h12, 32'h0,        32'h1234F6F0, 32'h0000F6F0, 1'b0, 3, 0, 32'h1234F6F0};
        vecs[5]  = '{OP_LH,  32'h12, 32'h0,        32'h1234F6F0, 32'hFFFFF6F0, 1'b0, 3, 0, 32'h1234F6F0};
        vecs[6]  = '{OP_LB,  32'h14, 32'h0,        32'h82345670, 32'hFFFFFF82, 1'b0, 3, 0, 32'h82345670};
        vecs[7]  = '{OP_LW,  32'h14, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 0, 32'hCAFEF00D};
        vecs[8]  = '{OP_SH,  32'h12, 32'h0000ABCD, 32'h11223344, 32'h00000000, 1'b0, 4, 1, 32'h1122ABCD};
        vecs[9]  = '{OP_SB,  32'h19, 32'hFFFFFF5A, 32'h11223344, 32'h00000000, 1'b0, 4, 1, 32'h115A3344};
        vecs[10] = '{OP_SH,  32'h1C, 32'h12345678, 32'hAABBCCDD, 32'h00000000, 1'b0, 4, 1, 32'h5678CCDD};
`ifdef LSU_UNALIGNED_EXC_EN
        vecs[11] = '{OP_LW,  32'h22, 32'h0,        32'h11223344, 32'h00000000, 1'b1, 1, 0, 32'h11223344};
        vecs[12] = '{OP_SH,  32'h21, 32'h0000BEEF, 32'h11223344, 32'h00000000, 1'b1, 1, 0, 32'h11223344};
`else
        vecs[11] = '{OP_LW,  32'h22, 32'h0,        32'h11223344, 32'h11223344, 1'b0, 3, 0, 32'h11223344};
        vecs[12] = '{OP_SH,  32'h21, 32'h0000BEEF, 32'h11223344, 32'h00000000, 1'b0, 4, 1, 32'hBEEF3344};
`endif

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst dc_wen", 32'(dc_wen), 32'd0);
        chk("rst dc_addr", dc_addr, 32'h0);
        chk("rst dc_wdata", dc_wdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i);

        // req_valid held high across LW then SW: second accept only after DONE.
        preload(6'd5, 32'h0BADF00D);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h14;
        req_wdata = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_op    = OP_SW;
                req_addr  = 32'h18;
                req_wdata = 32'h00C0FFEE;
            end
            chk($sformatf("hold c%0d busy", c), 32'(busy), (c == 4) ? 32'd0 : 32'd1);
            chk($sformatf("hold c%0d resp_valid", c), 32'(resp_valid), (c == 3 || c == 6) ? 32'd1 : 32'd0);
            chk($sformatf("hold c%0d dc_wen", c), 32'(dc_wen), (c == 5) ? 32'd1 : 32'd0);
            if (c == 3) chk("hold lw rdata", resp_rdata, 32'h0BADF00D);
            if (c == 6) req_valid = 1'b0;
        end
        @(negedge clk);
        chk("hold sw mem", mem[6], 32'h00C0FFEE);
        chk("hold writes", 32'(wr_cnt - w0), 32'd1);
        chk("hold idle", 32'(busy), 32'd0);

        // Reset during RD of an SB: request abandoned.
        preload(6'd6, 32'h11111111);
        w0 = wr_cnt;
        r0 = rv_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h18;
        req_wdata = 32'h22;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rd-rst in RD", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rd-rst busy", 32'(busy), 32'd0);
        chk("rd-rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rd-rst dc_wen", 32'(dc_wen), 32'd0);
        reset = 1'b0;
        rv_seen = 1'b0;
        wen_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            rv_seen  = rv_seen | resp_valid;
            wen_seen = wen_seen | dc_wen;
        end
        chk("rd-rst no resp later", 32'(rv_seen), 32'd0);
        chk("rd-rst no wen later", 32'(wen_seen), 32'd0);
        chk("rd-rst writes", 32'(wr_cnt - w0), 32'd0);
        chk("rd-rst resp count", 32'(rv_cnt - r0), 32'd0);
        chk("rd-rst mem", mem[6], 32'h11111111);

        // Reset during WR of an SB: the in-flight write lands, nothing more.
        preload(6'd7, 32'hAABBCCDD);
        w0 = wr_cnt;
        r0 = rv_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h1D;
        req_wdata = 32'h11;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr-rst in WR", 32'(dc_wen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("wr-rst busy", 32'(busy), 32'd0);
        chk("wr-rst dc_wen", 32'(dc_wen), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("wr-rst writes", 32'(wr_cnt - w0), 32'd1);
        chk("wr-rst mem", mem[7], 32'hAA11CCDD);
        chk("wr-rst resp count", 32'(rv_cnt - r0), 32'd0);

        // Reset wins over a simultaneous request.
        w0 = wr_cnt;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h3C;
        req_wdata = 32'h1;
        @(negedge clk);
        chk("prio busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        chk("prio writes", 32'(wr_cnt - w0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
